uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// UART 8N1 receiver with a single-byte command decoder driving waveform,
// noise and frequency-preset configuration registers.
module uart_cmd_decoder #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned HALF_BIT     = 1302
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_valid,
  output logic [1:0] wave_sel,
  output logic       noise_en,
  output logic [2:0] freq_sel,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (CLKS_PER_BIT > HALF_BIT) ? CLKS_PER_BIT : HALF_BIT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 3;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [1:0]          wave_q, wave_d;
  logic                noise_q, noise_d;
  logic [2:0]          freq_q, freq_d;
  logic                busy_q, busy_d;

  logic                dec_hit;
  logic                dec_wave_we, dec_noise_we, dec_freq_we;
  logic [1:0]          dec_wave;
  logic                dec_noise;
  logic [2:0]          dec_freq;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Command map on the assembled byte; each command owns exactly one field.
  always_comb begin
    dec_hit      = 1'b0;
    dec_wave_we  = 1'b0;
    dec_noise_we = 1'b0;
    dec_freq_we  = 1'b0;
    dec_wave     = 2'b00;
    dec_noise    = 1'b0;
    dec_freq     = 3'd0;
    case (shift_q)
      8'h54: begin dec_hit = 1'b1; dec_wave_we = 1'b1; dec_wave = 2'b00; end
      8'h53: begin dec_hit = 1'b1; dec_wave_we = 1'b1; dec_wave = 2'b01; end
      8'h51: begin dec_hit = 1'b1; dec_wave_we = 1'b1; dec_wave = 2'b10; end
      8'h57: begin dec_hit = 1'b1; dec_wave_we = 1'b1; dec_wave = 2'b11; end
      8'h4E: begin dec_hit = 1'b1; dec_noise_we = 1'b1; dec_noise = 1'b1; end
      8'h46: begin dec_hit = 1'b1; dec_noise_we = 1'b1; dec_noise = 1'b0; end
      8'h41, 8'h42, 8'h43, 8'h44, 8'h45: begin
        dec_hit     = 1'b1;
        dec_freq_we = 1'b1;
        dec_freq    = 3'(shift_q - 8'h41);
      end
      default: dec_hit = 1'b0;
    endcase
  end

  // Receiver FSM next-state, strobes and configuration updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    cmd_valid_d = 1'b0;
    wave_d      = wave_q;
    noise_d     = noise_q;
    freq_d      = freq_q;

    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[BYTE_W-1:1]};
          if (bit_idx_q == IDX_W'(BYTE_W - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            state_d    = ST_IDLE;
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (dec_hit) begin
              cmd_valid_d = 1'b1;
              if (dec_wave_we)  wave_d  = dec_wave;
              if (dec_noise_we) noise_d = dec_noise;
              if (dec_freq_we)  freq_d  = dec_freq;
            end
          end else begin
            state_d     = ST_WAIT_IDLE;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_sync_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      wave_q      <= 2'b00;
      noise_q     <= 1'b0;
      freq_q      <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      cmd_valid_q <= cmd_valid_d;
      wave_q      <= wave_d;
      noise_q     <= noise_d;
      freq_q      <= freq_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign cmd_valid = cmd_valid_q;
  assign wave_sel  = wave_q;
  assign noise_en  = noise_q;
  assign freq_sel  = freq_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed plus randomized frames for uart_cmd_decoder, checked against a
// byte-level command model of the configuration registers.
module tb_uart_cmd_decoder;

  localparam int unsigned CPB  = 32;
  localparam int unsigned HALF = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_valid;
  logic [1:0] wave_sel;
  logic       noise_en;
  logic [2:0] freq_sel;
  logic       busy;

  uart_cmd_decoder #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .cmd_valid(cmd_valid),
    .wave_sel (wave_sel),
    .noise_en (noise_en),
    .freq_sel (freq_sel),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe observer: counts events, records what was presented with them.
  int         n_rxv = 0;
  int         n_cmd = 0;
  int         n_ferr = 0;
  int         n_bad = 0;
  logic [7:0] cap_hist [0:255];
  logic [1:0] cap_wave;
  logic       cap_noise;
  logic [2:0] cap_freq;
  bit         prev_rxv = 0, prev_cmd = 0, prev_ferr = 0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      cap_hist[n_rxv[7:0]] = rx_data;
      cap_wave  = wave_sel;
      cap_noise = noise_en;
      cap_freq  = freq_sel;
      n_rxv++;
      if (prev_rxv) n_bad++;
      if (frame_err !== 1'b0) n_bad++;
    end
    if (cmd_valid === 1'b1) begin
      n_cmd++;
      if (prev_cmd) n_bad++;
      if (rx_valid !== 1'b1) n_bad++;
    end
    if (frame_err === 1'b1) begin
      n_ferr++;
      if (prev_ferr) n_bad++;
      if (cmd_valid !== 1'b0) n_bad++;
    end
    prev_rxv  = (rx_valid === 1'b1);
    prev_cmd  = (cmd_valid === 1'b1);
    prev_ferr = (frame_err === 1'b1);
  end

  // Reference model of the decoder's visible state.
  logic [1:0] exp_wave;
  logic       exp_noise;
  logic [2:0] exp_freq;
  logic [7:0] exp_data;

  task automatic model_reset();
    exp_wave  = 2'b00;
    exp_noise = 1'b0;
    exp_freq  = 3'd0;
    exp_data  = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit is_cmd);
    is_cmd   = 1'b1;
    exp_data = b;
    case (b)
      "T": exp_wave = 2'd0;
      "S": exp_wave = 2'd1;
      "Q": exp_wave = 2'd2;
      "W": exp_wave = 2'd3;
      "N": exp_noise = 1'b1;
      "F": exp_noise = 1'b0;
      default: begin
        if (b >= "A" && b <= "E") exp_freq = 3'(int'(b) - int'("A"));
        else is_cmd = 1'b0;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int unsigned cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, " wave_sel"}, 32'(wave_sel), 32'(exp_wave));
    chk({tag, " noise_en"}, 32'(noise_en), 32'(exp_noise));
    chk({tag, " freq_sel"}, 32'(freq_sel), 32'(exp_freq));
    chk({tag, " rx_data"},  32'(rx_data),  32'(exp_data));
  endtask

  task automatic do_byte(input logic [7:0] b, input int unsigned gap);
    int  r0, c0, f0;
    bit  is_cmd;
    string tag;
    tag = $sformatf("byte%02h", b);
    r0 = n_rxv; c0 = n_cmd; f0 = n_ferr;
    model_byte(b, is_cmd);
    send_frame(b, 1'b1);
    repeat (gap) @(negedge clk);
    chk({tag, " rx_valid count"},  32'(n_rxv - r0), 32'd1);
    chk({tag, " cmd_valid count"}, 32'(n_cmd - c0), is_cmd ? 32'd1 : 32'd0);
    chk({tag, " frame_err count"}, 32'(n_ferr - f0), 32'd0);
    chk({tag, " data at strobe"},  32'(cap_hist[8'(n_rxv - 1)]), 32'(b));
    chk({tag, " wave at strobe"},  32'(cap_wave),  32'(exp_wave));
    chk({tag, " noise at strobe"}, 32'(cap_noise), 32'(exp_noise));
    chk({tag, " freq at strobe"},  32'(cap_freq),  32'(exp_freq));
    chk_outputs(tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " strobe shape"}, 32'(n_bad), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [7:0] cmd_list [0:14];
  int         r0, c0, f0;
  bit         dummy;

  initial begin
    cmd_list = '{8'h54, 8'h53, 8'h51, 8'h57, 8'h4E, 8'h46, 8'h41, 8'h42,
                 8'h43, 8'h44, 8'h45, 8'h5A, 8'h00, 8'hFF, 8'h47};
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    apply_reset();
    chk_outputs("reset");
    chk("reset rx_valid",  32'(rx_valid),  32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset busy",      32'(busy),      32'd0);

    // Waveform, noise and frequency commands, plus an unrecognised byte.
    do_byte(8'h54, 6);
    do_byte(8'h53, 6);
    do_byte(8'h51, 6);
    do_byte(8'h57, 6);
    do_byte(8'h4E, 6);
    do_byte(8'h46, 6);
    do_byte(8'h41, 6);
    do_byte(8'h45, 6);
    do_byte(8'h5A, 6);
    do_byte(8'h45, 6);

    // Bad stop bit, line then held low: frame error and wait for idle.
    r0 = n_rxv; c0 = n_cmd; f0 = n_ferr;
    send_frame(8'h44, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr frame_err count", 32'(n_ferr - f0), 32'd1);
    chk("ferr rx_valid count",  32'(n_rxv - r0),  32'd0);
    chk("ferr cmd_valid count", 32'(n_cmd - c0),  32'd0);
    chk("ferr busy in wait",    32'(busy),        32'd1);
    chk_outputs("ferr held");
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("ferr busy released",   32'(busy),        32'd0);
    chk("ferr strobe shape",    32'(n_bad),       32'd0);
    do_byte(8'h43, 6);

    // Short low glitch: rejected at the start-bit midpoint.
    r0 = n_rxv; c0 = n_cmd; f0 = n_ferr;
    drive_bit(1'b0, 6);
    chk("glitch busy high", 32'(busy), 32'd1);
    drive_bit(1'b1, HALF + 10);
    chk("glitch busy low",   32'(busy), 32'd0);
    chk("glitch no strobes", 32'((n_rxv - r0) + (n_cmd - c0) + (n_ferr - f0)), 32'd0);
    chk_outputs("glitch held");

    // Back-to-back frames with no idle gap.
    r0 = n_rxv; c0 = n_cmd;
    model_byte(8'h54, dummy);
    model_byte(8'h4E, dummy);
    send_frame(8'h54, 1'b1);
    send_frame(8'h4E, 1'b1);
    repeat (6) @(negedge clk);
    chk("b2b rx_valid count",  32'(n_rxv - r0), 32'd2);
    chk("b2b cmd_valid count", 32'(n_cmd - c0), 32'd2);
    chk("b2b first byte",  32'(cap_hist[8'(r0)]),     32'h54);
    chk("b2b second byte", 32'(cap_hist[8'(r0 + 1)]), 32'h4E);
    chk_outputs("b2b");

    // Randomized bytes, half drawn from the command set.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      if ($urandom_range(0, 1) == 0) b = cmd_list[$urandom_range(0, 14)];
      else b = 8'($urandom_range(0, 255));
      do_byte(b, 4 + $urandom_range(0, 12));
    end

    // Reset in the middle of data bit 4 of 'W'.
    r0 = n_rxv; c0 = n_cmd; f0 = n_ferr;
    begin
      logic [7:0] w;
      w = 8'h57;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive_bit(w[i], CPB);
      drive_bit(w[4], CPB / 2);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (2 * CPB) @(negedge clk);
    chk("abort no strobes", 32'((n_rxv - r0) + (n_cmd - c0) + (n_ferr - f0)), 32'd0);
    chk("abort busy",       32'(busy), 32'd0);
    chk_outputs("abort reset values");
    do_byte(8'h53, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
